// File: rtl/cal_force_sequencer.sv
// cal_force_sequencer: sample-rate strobe, button debouncer and DAC calibration output sequencer.
// Build option: define CAL_SWEEP_EN to include the per-channel level sweep mode (mode 3).
module cal_force_sequencer #(
    parameter int unsigned W             = 16,
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned DIV_LOG2      = 8,
    parameter int unsigned DEBOUNCE_LOG2 = 16,
    parameter int unsigned HOLD_STROBES  = 48000,
    localparam int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk_256fs,
    input  logic                  rst,
    input  logic                  button_i,
    input  logic [CHANNELS*W-1:0] dsp_in,
    output logic                  strobe_o,
    output logic [CHANNELS*W-1:0] dac_out,
    output logic [1:0]            mode_o,
    output logic [CH_W-1:0]       active_ch_o,
    output logic [2:0]            step_o
);

    localparam int unsigned DIV_W = DIV_LOG2;
    localparam int unsigned DB_W  = DEBOUNCE_LOG2;

    localparam logic [DB_W-1:0] DB_LAST   = '1;
    localparam logic [W-1:0]    LVL_MIN   = W'(1) << (W - 1);
    localparam logic [W-1:0]    LVL_MAX   = ~LVL_MIN;
    localparam logic [W-1:0]    LVL_HALF  = W'(1) << (W - 2);
    localparam logic [W-1:0]    LVL_NHALF = W'(0) - LVL_HALF;

`ifdef CAL_SWEEP_EN
    localparam int unsigned     HOLD_W    = $clog2(HOLD_STROBES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STROBES - 1);
    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_FMIN  = 2'd1,
        MODE_FMAX  = 2'd2,
        MODE_SWEEP = 2'd3
    } mode_e;
`else
    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_FMIN  = 2'd1,
        MODE_FMAX  = 2'd2
    } mode_e;
`endif

    logic [DIV_W-1:0]      div_cnt_q;
    logic                  strobe_q;
    logic [1:0]            sync_q;
    logic [DB_W-1:0]       db_cnt_q, db_cnt_d;
    logic                  db_q, db_d;
    logic                  press_q, press_d;
    mode_e                 mode_q, mode_d;
    logic [CHANNELS*W-1:0] dac_q, dac_d;

`ifdef CAL_SWEEP_EN
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [2:0]            step_q, step_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;

    // Sweep level table indexed by step
    function automatic logic [W-1:0] step_level(input logic [2:0] s);
        case (s)
            3'd0:    step_level = LVL_MIN;
            3'd1:    step_level = LVL_NHALF;
            3'd2:    step_level = '0;
            3'd3:    step_level = LVL_HALF;
            3'd4:    step_level = LVL_MAX;
            default: step_level = '0;
        endcase
    endfunction
`endif

    // Free-running divider; strobe is the registered wrap flag of the counter
    always_ff @(posedge clk_256fs) begin
        if (rst) begin
            div_cnt_q <= '0;
            strobe_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
            strobe_q  <= (div_cnt_q == '0);
        end
    end

    // Debounce: adopt the synchronised level once it has differed for 2^DEBOUNCE_LOG2 clocks
    always_comb begin
        db_cnt_d = '0;
        db_d     = db_q;
        press_d  = 1'b0;
        if (sync_q[1] != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d    = sync_q[1];
                press_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Button synchroniser and debounce registers
    always_ff @(posedge clk_256fs) begin
        if (rst) begin
            sync_q   <= '0;
            db_cnt_q <= '0;
            db_q     <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], button_i};
            db_cnt_q <= db_cnt_d;
            db_q     <= db_d;
            press_q  <= press_d;
        end
    end

    // Mode FSM next state; a press takes priority over a sweep advance
    always_comb begin
        mode_d = mode_q;
`ifdef CAL_SWEEP_EN
        ch_d   = ch_q;
        step_d = step_q;
        hold_d = hold_q;
`endif
        if (press_q) begin
            case (mode_q)
                MODE_PASS:  mode_d = MODE_FMIN;
                MODE_FMIN:  mode_d = MODE_FMAX;
`ifdef CAL_SWEEP_EN
                MODE_FMAX:  mode_d = MODE_SWEEP;
`else
                MODE_FMAX:  mode_d = MODE_PASS;
`endif
                default:    mode_d = MODE_PASS;
            endcase
`ifdef CAL_SWEEP_EN
            ch_d   = '0;
            step_d = '0;
            hold_d = '0;
        end else if ((mode_q == MODE_SWEEP) && strobe_q) begin
            if (hold_q == HOLD_LAST) begin
                hold_d = '0;
                if (step_q == 3'd4) begin
                    step_d = '0;
                    ch_d   = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
                end else begin
                    step_d = step_q + 3'd1;
                end
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
`endif
        end
    end

    // Mode FSM state register
    always_ff @(posedge clk_256fs) begin
        if (rst) begin
            mode_q <= MODE_PASS;
`ifdef CAL_SWEEP_EN
            ch_q   <= '0;
            step_q <= '0;
            hold_q <= '0;
`endif
        end else begin
            mode_q <= mode_d;
`ifdef CAL_SWEEP_EN
            ch_q   <= ch_d;
            step_q <= step_d;
            hold_q <= hold_d;
`endif
        end
    end

    // Per-channel output selection, captured only on strobe cycles
    always_comb begin
        dac_d = dac_q;
        if (strobe_q) begin
            for (int c = 0; c < CHANNELS; c++) begin
                case (mode_q)
                    MODE_PASS:  dac_d[c*W +: W] = dsp_in[c*W +: W];
                    MODE_FMIN:  dac_d[c*W +: W] = LVL_MIN;
                    MODE_FMAX:  dac_d[c*W +: W] = LVL_MAX;
`ifdef CAL_SWEEP_EN
                    MODE_SWEEP: dac_d[c*W +: W] = (ch_q == CH_W'(c)) ? step_level(step_q) : '0;
`endif
                    default:    dac_d[c*W +: W] = '0;
                endcase
            end
        end
    end

    // DAC output register
    always_ff @(posedge clk_256fs) begin
        if (rst) begin
            dac_q <= '0;
        end else begin
            dac_q <= dac_d;
        end
    end

    assign strobe_o = strobe_q;
    assign dac_out  = dac_q;
    assign mode_o   = mode_q;

`ifdef CAL_SWEEP_EN
    assign active_ch_o = ch_q;
    assign step_o      = step_q;
`else
    assign active_ch_o = '0;
    assign step_o      = '0;

    logic unused_hold_c;
    assign unused_hold_c = (HOLD_STROBES == 0);
`endif

endmodule

// File: tb/tb_cal_force_sequencer.sv
// Bench for cal_force_sequencer: behavioural model plus literal spot checks.
`timescale 1ns/1ps
module tb_cal_force_sequencer;

    localparam int unsigned W        = 16;
    localparam int unsigned C        = 4;
    localparam int unsigned DIV_LOG2 = 8;
    localparam int unsigned DEB_LOG2 = 4;
    localparam int unsigned HOLD     = 2;
    localparam int unsigned PERIOD   = 1 << DIV_LOG2;
    localparam int unsigned DEB_N    = 1 << DEB_LOG2;
    localparam int unsigned LAT      = 2 + DEB_N + 1;
`ifdef CAL_SWEEP_EN
    localparam int NMODES = 4;
`else
    localparam int NMODES = 3;
`endif

    logic           clk_256fs = 1'b0;
    logic           rst       = 1'b1;
    logic           button_i  = 1'b0;
    logic [C*W-1:0] dsp_in    = '0;
    logic           strobe_o;
    logic [C*W-1:0] dac_out;
    logic [1:0]     mode_o;
    logic [1:0]     active_ch_o;
    logic [2:0]     step_o;

    cal_force_sequencer #(
        .W(W), .CHANNELS(C), .DIV_LOG2(DIV_LOG2),
        .DEBOUNCE_LOG2(DEB_LOG2), .HOLD_STROBES(HOLD)
    ) dut (
        .clk_256fs(clk_256fs), .rst(rst), .button_i(button_i), .dsp_in(dsp_in),
        .strobe_o(strobe_o), .dac_out(dac_out), .mode_o(mode_o),
        .active_ch_o(active_ch_o), .step_o(step_o)
    );

    always #5 clk_256fs = ~clk_256fs;

    int checks   = 0;
    int failures = 0;

    // Model state: time since reset, button history, debounced level, mode, sweep progress
    int          m_t      = 0;
    bit          m_strobe = 0;
    bit          m_press  = 0;
    bit          m_db     = 0;
    int          m_run    = 0;
    bit          m_b1     = 0;
    bit          m_b2     = 0;
    int          m_mode   = 0;
    int          m_n      = 0;
    logic [63:0] m_dac    = '0;
    bit          coincide_seen = 0;
    bit          chk_en   = 0;
    bit          rand_dsp = 0;

    logic [15:0] lvl [5] = '{16'h8000, 16'hC000, 16'h0000, 16'h4000, 16'h7FFF};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_step(input int n);
        return (n / HOLD) % 5;
    endfunction

    function automatic int m_ch(input int n);
        return (n / (5 * HOLD)) % C;
    endfunction

    // Expected DAC word for a mode and sweep position
    function automatic logic [63:0] m_out(input int mode, input int n, input logic [63:0] dsp);
        logic [63:0] r;
        r = '0;
        case (mode)
            0: r = dsp;
            1: r = {4{16'h8000}};
            2: r = {4{16'h7FFF}};
            default: r[m_ch(n)*16 +: 16] = lvl[m_step(n)];
        endcase
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        bit s_old;
        bit p_old;
        s_old = m_strobe;
        p_old = m_press;
        if (rst) begin
            m_t = 0; m_strobe = 0; m_press = 0; m_db = 0; m_run = 0;
            m_b1 = 0; m_b2 = 0; m_mode = 0; m_n = 0; m_dac = '0;
            return;
        end
        if (s_old) m_dac = m_out(m_mode, m_n, dsp_in);
        if (p_old) begin
            if (m_mode == 3 && s_old && (m_n % HOLD) == HOLD - 1) coincide_seen = 1;
            m_mode = (m_mode + 1) % NMODES;
            m_n    = 0;
        end else if (m_mode == 3 && s_old) begin
            m_n++;
        end
        m_press = 0;
        if (m_b2 != m_db) begin
            m_run++;
            if (m_run == DEB_N) begin
                m_db    = m_b2;
                m_press = m_b2;
                m_run   = 0;
            end
        end else begin
            m_run = 0;
        end
        m_b2 = m_b1;
        m_b1 = button_i;
        m_t++;
        m_strobe = ((m_t - 1) % PERIOD) == 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_256fs);
            model_edge();
            #1;
            if (rand_dsp) dsp_in = {$urandom, $urandom};
        end
    endtask

    // Run until the next strobe has been consumed, so the newly loaded DAC word is visible
    task automatic next_strobe();
        int k;
        k = 0;
        while (!m_strobe && k < int'(PERIOD) + 4) begin
            cyc(1);
            k++;
        end
        if (!m_strobe) begin
            checks++;
            failures++;
            $display("FAIL strobe_wait: no strobe within %0d cycles", k);
        end
        cyc(1);
    endtask

    task automatic press();
        button_i = 1'b1;
        cyc(30);
        button_i = 1'b0;
        cyc(30);
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk_256fs) begin
        if (chk_en) begin
            chk("strobe", 64'(strobe_o), 64'(m_strobe));
            chk("dac", dac_out, m_dac);
            chk("mode", 64'(mode_o), 64'(m_mode));
            chk("active_ch", 64'(active_ch_o), 64'(m_ch(m_n)));
            chk("step", 64'(step_o), 64'(m_step(m_n)));
        end
    end

    initial begin
        // Reset
        rst = 1'b1;
        cyc(1);
        chk_en = 1;
        cyc(2);
        chk("rst_strobe", 64'(strobe_o), 64'd0);
        chk("rst_dac", dac_out, 64'd0);
        chk("rst_mode", 64'(mode_o), 64'd0);
        rst = 1'b0;

        // Strobe cadence: cycle label = edges since release + 1
        for (int k = 1; k <= 515; k++) begin
            cyc(1);
            if (k + 1 == 2 || k + 1 == 258 || k + 1 == 514)
                chk("strobe_at_cycle", 64'(strobe_o), 64'd1);
            else if (k + 1 == 3 || k + 1 == 257 || k + 1 == 259 || k + 1 == 513)
                chk("strobe_off_cycle", 64'(strobe_o), 64'd0);
            if (k == 1) chk("dac_before_first_strobe", dac_out, 64'd0);
        end

        // Passthrough
        dsp_in = {16'h1234, 16'hFFFB, 16'h7FFF, 16'h0000};
        next_strobe();
        chk("pass_literal", dac_out, 64'h1234_FFFB_7FFF_0000);
        rand_dsp = 1;
        cyc(50);
        chk("pass_hold", dac_out, 64'h1234_FFFB_7FFF_0000);
        next_strobe();

        // Bouncing button must not change mode
        for (int i = 0; i < 25; i++) begin
            button_i = ~button_i;
            cyc(8);
        end
        chk("bounce_mode", 64'(mode_o), 64'd0);
        cyc(30);
        chk("press1_mode", 64'(mode_o), 64'd1);
        button_i = 1'b0;
        cyc(40);
        next_strobe();
        chk("force_min", dac_out, {4{16'h8000}});

        press();
        chk("press2_mode", 64'(mode_o), 64'd2);
        next_strobe();
        chk("force_max", dac_out, {4{16'h7FFF}});

`ifdef CAL_SWEEP_EN
        next_strobe();
        press();
        chk("press3_mode", 64'(mode_o), 64'd3);
        for (int i = 0; i < 10; i++) begin
            next_strobe();
            chk("sweep_ch0", dac_out, 64'(lvl[i / 2]));
        end
        chk("sweep_ch1", 64'(active_ch_o), 64'd1);
        for (int i = 0; i < 30; i++) next_strobe();
        chk("sweep_last", dac_out, 64'h7FFF_0000_0000_0000);
        chk("sweep_wrap_ch", 64'(active_ch_o), 64'd0);
        chk("sweep_wrap_step", 64'(step_o), 64'd0);

        // Press lands on the strobe that expires the hold counter
        cyc(int'(2 * PERIOD - LAT));
        button_i = 1'b1;
        cyc(30);
        button_i = 1'b0;
        cyc(30);
        chk("coincide_hit", 64'(coincide_seen), 64'd1);
        chk("coincide_mode", 64'(mode_o), 64'd0);
        chk("coincide_step", 64'(step_o), 64'd0);

        // Reset during sweep step 3
        press();
        press();
        press();
        for (int i = 0; i < 20 && m_step(m_n) != 3; i++) next_strobe();
        chk("sweep_step3", 64'(step_o), 64'd3);
        cyc(5);
`else
        press();
        chk("press3_wrap", 64'(mode_o), 64'd0);
        button_i = 1'b1;
        cyc(10);
`endif
        rst = 1'b1;
        cyc(1);
        chk("midrst_strobe", 64'(strobe_o), 64'd0);
        chk("midrst_dac", dac_out, 64'd0);
        chk("midrst_mode", 64'(mode_o), 64'd0);
        chk("midrst_ch", 64'(active_ch_o), 64'd0);
        chk("midrst_step", 64'(step_o), 64'd0);
        button_i = 1'b0;
        rst = 1'b0;

        // Randomised button activity with random DSP data
        for (int total = 0; total < 6000; ) begin
            int len;
            len = $urandom_range(1, 45);
            button_i = 1'($urandom_range(0, 1));
            cyc(len);
            total += len;
        end
        button_i = 1'b0;
        cyc(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
